// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller.
// Contents:
//   - register offsets relative to BASE (ICTRL, IMASK, IPEND, ICAUSE)
//   - bit positions of GIE in ICTRL and of the valid flag in ICAUSE
//   - the controller FSM state encoding
package interrupt_controller_pkg;

  localparam int unsigned ICTRL_OFS  = 0;
  localparam int unsigned IMASK_OFS  = 4;
  localparam int unsigned IPEND_OFS  = 8;
  localparam int unsigned ICAUSE_OFS = 12;

  localparam int GIE_BIT         = 0;
  localparam int CAUSE_VALID_BIT = 31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } ctrlState_t;

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Fixed-priority encoder: returns the index of the lowest set bit of
// reqVec (bit 0 has the highest priority) and a flag telling whether any
// bit is set.
// Ports:
//   reqVec    in   NUM_IRQ  candidate request vector
//   winnerId  out  4        index of the lowest set bit (0 when none)
//   anyValid  out  1        reqVec has at least one bit set
module interrupt_controller_priority_encoder #(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] reqVec,
  output logic [3:0]         winnerId,
  output logic               anyValid
);

  // Scan from the top down so the lowest set index is the final assignment.
  always_comb begin
    winnerId = '0;
    anyValid = |reqVec;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (reqVec[i]) begin
        winnerId = 4'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller sitting between the level-sensitive
// device interrupt lines and the CPU pipeline. It keeps the global enable
// (ICTRL.GIE), the per-line mask (IMASK), a registered view of the lines
// (IPEND) and the in-service cause (ICAUSE), and runs a single-level
// request / acknowledge / return handshake with the CPU.
//
// Handshake: intr_req is held high for as long as the FSM sits in REQUEST.
// The CPU accepts by asserting intr_ack while intr_req is high; the
// controller then moves to SERVICE and drops intr_req. The CPU ends the
// handler with intr_ret while in SERVICE. intr_ack outside REQUEST and
// intr_ret outside SERVICE are ignored. A request is withdrawn (back to
// IDLE) if its line stops being eligible before the ack arrives.
//
// Ports:
//   clk         in   1        system clock
//   reset       in   1        synchronous active-low reset
//   we, re      in   1        CPU store / load strobes
//   memAddr     in   BITS     bus address
//   dataBusIn   in   BITS     store data
//   irq_in      in   NUM_IRQ  level interrupt lines, bit i = device i
//   intr_ack    in   1        CPU vectored to the handler
//   intr_ret    in   1        CPU executed return-from-interrupt
//   dataBusOut  out  BITS     load data, zero when not selected
//   intr_req    out  1        interrupt request to the CPU
//   intr_id     out  4        id of the requested / in-service line
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int              BITS    = 32,
  parameter int              NUM_IRQ = 4,
  parameter logic [BITS-1:0] BASE    = 32'hF0000100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic               re,
  input  logic [BITS-1:0]    memAddr,
  input  logic [BITS-1:0]    dataBusIn,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               intr_ack,
  input  logic               intr_ret,
  output logic [BITS-1:0]    dataBusOut,
  output logic               intr_req,
  output logic [3:0]         intr_id
);

  localparam logic [BITS-1:0] ICTRL_ADDR  = BASE + BITS'(ICTRL_OFS);
  localparam logic [BITS-1:0] IMASK_ADDR  = BASE + BITS'(IMASK_OFS);
  localparam logic [BITS-1:0] IPEND_ADDR  = BASE + BITS'(IPEND_OFS);
  localparam logic [BITS-1:0] ICAUSE_ADDR = BASE + BITS'(ICAUSE_OFS);

  ctrlState_t         state;
  ctrlState_t         nextState;
  logic               gie;
  logic [NUM_IRQ-1:0] imask;
  logic [NUM_IRQ-1:0] ipend;
  logic [NUM_IRQ-1:0] elig;
  logic [3:0]         idReg;
  logic [3:0]         winnerId;
  logic               anyElig;
  logic               idStillElig;
  logic               latchWinner;
  logic               ackTaken;
  logic               retTaken;
  logic               wrIctrl;
  logic               wrImask;
  logic               unusedDataBits;

  // Only the low NUM_IRQ bits of store data are ever loaded.
  assign unusedDataBits = ^dataBusIn[BITS-1:NUM_IRQ];

  assign wrIctrl = we && (memAddr == ICTRL_ADDR);
  assign wrImask = we && (memAddr == IMASK_ADDR);

  assign elig    = ipend & imask & {NUM_IRQ{gie}};
  assign intr_id = idReg;

  interrupt_controller_priority_encoder #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio (
    .reqVec   (elig),
    .winnerId (winnerId),
    .anyValid (anyElig)
  );

  // Is the line that was latched at request time still eligible? The loop
  // avoids indexing elig with a 4-bit id wider than its range.
  always_comb begin
    idStillElig = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (idReg == 4'(i)) begin
        idStillElig = elig[i];
      end
    end
  end

  // FSM next state and handshake strobes.
  always_comb begin
    nextState   = state;
    intr_req    = 1'b0;
    latchWinner = 1'b0;
    ackTaken    = 1'b0;
    retTaken    = 1'b0;
    case (state)
      IDLE: begin
        if (anyElig) begin
          nextState   = REQUEST;
          latchWinner = 1'b1;
        end
      end
      REQUEST: begin
        intr_req = 1'b1;
        // Ack beats a withdrawal seen in the same cycle.
        if (intr_ack) begin
          nextState = SERVICE;
          ackTaken  = 1'b1;
        end else if (!idStillElig) begin
          nextState = IDLE;
        end
      end
      SERVICE: begin
        if (intr_ret) begin
          nextState = IDLE;
          retTaken  = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Register file. The handshake overrides on GIE come after the bus write
  // so that ack (force 0) and return (force 1) win over a same-cycle store.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gie   <= 1'b0;
      imask <= '0;
      ipend <= '0;
      idReg <= '0;
    end else begin
      ipend <= irq_in;
      if (wrIctrl) begin
        gie <= dataBusIn[GIE_BIT];
      end
      if (ackTaken) begin
        gie <= 1'b0;
      end else if (retTaken) begin
        gie <= 1'b1;
      end
      if (wrImask) begin
        imask <= dataBusIn[NUM_IRQ-1:0];
      end
      if (latchWinner) begin
        idReg <= winnerId;
      end
    end
  end

  // Read mux; zero when not selected so several slaves can be OR-ed.
  always_comb begin
    dataBusOut = '0;
    if (re && !we) begin
      case (memAddr)
        ICTRL_ADDR:  dataBusOut[GIE_BIT] = gie;
        IMASK_ADDR:  dataBusOut[NUM_IRQ-1:0] = imask;
        IPEND_ADDR:  dataBusOut[NUM_IRQ-1:0] = ipend;
        ICAUSE_ADDR: begin
          if (state == SERVICE) begin
            dataBusOut[CAUSE_VALID_BIT] = 1'b1;
            dataBusOut[3:0]             = idReg;
          end
        end
        default: dataBusOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller. Expected values
// are pushed into a queue as each step is driven and popped when the
// corresponding DUT output is sampled (1 time unit after the rising edge).
module tb_interrupt_controller;

  localparam logic [31:0] A_CTRL  = 32'hF000_0100;
  localparam logic [31:0] A_MASK  = 32'hF000_0104;
  localparam logic [31:0] A_PEND  = 32'hF000_0108;
  localparam logic [31:0] A_CAUSE = 32'hF000_010C;

  logic        clk;
  logic        reset;
  logic        we;
  logic        re;
  logic [31:0] memAddr;
  logic [31:0] dataBusIn;
  logic [3:0]  irq_in;
  logic        intr_ack;
  logic        intr_ret;
  logic [31:0] dataBusOut;
  logic        intr_req;
  logic [3:0]  intr_id;

  logic [31:0] exp_q[$];
  int          vectors;
  int          miscompares;
  logic [31:0] rd;

  interrupt_controller #(
    .BITS    (32),
    .NUM_IRQ (4),
    .BASE    (32'hF0000100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .re         (re),
    .memAddr    (memAddr),
    .dataBusIn  (dataBusIn),
    .irq_in     (irq_in),
    .intr_ack   (intr_ack),
    .intr_ret   (intr_ret),
    .dataBusOut (dataBusOut),
    .intr_req   (intr_req),
    .intr_id    (intr_id)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    memAddr   = addr;
    dataBusIn = data;
    we        = 1'b1;
    tick();
    we        = 1'b0;
    memAddr   = '0;
    dataBusIn = '0;
  endtask

  // Purely combinational read between edges.
  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    memAddr = addr;
    re      = 1'b1;
    #1;
    data    = dataBusOut;
    re      = 1'b0;
    memAddr = '0;
  endtask

  // Scoreboard
  task automatic expectVal(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %h with no expected value queued", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic expReq(input logic req, input logic [3:0] id);
    expectVal(32'(req));
    expectVal(32'(id));
  endtask

  task automatic cmpReq(input string tag);
    checkVal({tag, "_req"}, 32'(intr_req));
    checkVal({tag, "_id"}, 32'(intr_id));
  endtask

  task automatic expRead(input string tag, input logic [31:0] addr,
                         input logic [31:0] v);
    logic [31:0] d;
    expectVal(v);
    busRead(addr, d);
    checkVal(tag, d);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b0; we = 1'b0; re = 1'b0; memAddr = '0; dataBusIn = '0;
    irq_in = '0; intr_ack = 1'b0; intr_ret = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();

    // Reset state
    expReq(1'b0, 4'd0); cmpReq("rst");
    expectVal(32'h0); checkVal("rst_idlebus", dataBusOut);
    expRead("rst_ictrl", A_CTRL, 32'h0);
    expRead("rst_imask", A_MASK, 32'h0);
    expRead("rst_ipend", A_PEND, 32'h0);
    expRead("rst_icause", A_CAUSE, 32'h0);

    // Latency: request two edges after irq_in is sampled
    busWrite(A_CTRL, 32'h1);
    busWrite(A_MASK, 32'h1);
    irq_in = 4'b0001;
    expReq(1'b0, 4'd0); tick(); cmpReq("lat_edge1");
    expReq(1'b1, 4'd0); tick(); cmpReq("lat_edge2");
    irq_in = 4'b0000;
    expReq(1'b1, 4'd0); tick(); cmpReq("lat_drop1");
    expReq(1'b0, 4'd0); tick(); cmpReq("lat_drop2");

    // Priority, ack, service, return, re-request
    busWrite(A_MASK, 32'hF);
    irq_in = 4'b1010;
    tick();
    expReq(1'b1, 4'd1); tick(); cmpReq("prio_1010");
    intr_ack = 1'b1;
    expReq(1'b0, 4'd1); tick(); cmpReq("ack");
    intr_ack = 1'b0;
    expRead("svc_icause", A_CAUSE, 32'h8000_0001);
    expRead("svc_ictrl", A_CTRL, 32'h0);
    intr_ret = 1'b1;
    expReq(1'b0, 4'd1); tick(); cmpReq("ret");
    intr_ret = 1'b0;
    expRead("ret_icause", A_CAUSE, 32'h0);
    expRead("ret_ictrl", A_CTRL, 32'h1);
    expReq(1'b1, 4'd1); tick(); cmpReq("rereq");
    irq_in = 4'b0000;
    tick();
    expReq(1'b0, 4'd1); tick(); cmpReq("rereq_drop");

    // Withdrawal by device
    irq_in = 4'b0100;
    tick();
    expReq(1'b1, 4'd2); tick(); cmpReq("req2");
    irq_in = 4'b0000;
    tick();
    expReq(1'b0, 4'd2); tick(); cmpReq("wd_dev");
    expRead("wd_dev_icause", A_CAUSE, 32'h0);

    // Withdrawal by mask
    irq_in = 4'b0100;
    tick();
    expReq(1'b1, 4'd2); tick(); cmpReq("req2b");
    expReq(1'b1, 4'd2); busWrite(A_MASK, 32'hB); cmpReq("mask_wr");
    expReq(1'b0, 4'd2); tick(); cmpReq("wd_mask");
    expReq(1'b0, 4'd2); tick(); cmpReq("masked_idle");
    irq_in = 4'b0000;
    tick();
    busWrite(A_MASK, 32'hF);

    // No nesting: higher priority arrival during SERVICE waits
    irq_in = 4'b1000;
    tick();
    expReq(1'b1, 4'd3); tick(); cmpReq("req3");
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
    irq_in = 4'b1001;
    tick(); tick();
    expReq(1'b0, 4'd3); tick(); cmpReq("svc3_hold");
    intr_ret = 1'b1;
    expReq(1'b0, 4'd3); tick(); cmpReq("ret3");
    intr_ret = 1'b0;
    expReq(1'b1, 4'd0); tick(); cmpReq("after_ret3");

    // Ignored handshakes: ret in REQUEST, ack in IDLE
    intr_ret = 1'b1;
    expReq(1'b1, 4'd0); tick(); cmpReq("ret_in_req");
    intr_ret = 1'b0;
    irq_in = 4'b0000;
    tick();
    expReq(1'b0, 4'd0); tick(); cmpReq("back_idle");
    intr_ack = 1'b1;
    expReq(1'b0, 4'd0); tick(); cmpReq("ack_in_idle");
    intr_ack = 1'b0;
    expRead("ack_idle_icause", A_CAUSE, 32'h0);

    // Ack coinciding with the line dropping out of elig: ack wins
    irq_in = 4'b0010;
    tick();
    expReq(1'b1, 4'd1); tick(); cmpReq("req1");
    irq_in = 4'b0000;
    expReq(1'b1, 4'd1); tick(); cmpReq("req1_hold");
    intr_ack = 1'b1;
    expReq(1'b0, 4'd1); tick(); cmpReq("ack_vs_drop");
    intr_ack = 1'b0;
    expRead("ack_vs_drop_icause", A_CAUSE, 32'h8000_0001);

    // Handler writes GIE in SERVICE; return still forces GIE=1
    busWrite(A_CTRL, 32'h1);
    expRead("svc_gie_wr", A_CTRL, 32'h1);
    expRead("svc_gie_icause", A_CAUSE, 32'h8000_0001);
    memAddr = A_CTRL; dataBusIn = 32'h0; we = 1'b1; intr_ret = 1'b1;
    tick();
    we = 1'b0; intr_ret = 1'b0; memAddr = '0;
    expRead("ret_vs_wr_gie", A_CTRL, 32'h1);
    expRead("ret_vs_wr_icause", A_CAUSE, 32'h0);

    // GIE store coinciding with ack: forced 0 wins
    irq_in = 4'b0010;
    tick();
    expReq(1'b1, 4'd1); tick(); cmpReq("req1c");
    memAddr = A_CTRL; dataBusIn = 32'h1; we = 1'b1; intr_ack = 1'b1;
    tick();
    we = 1'b0; intr_ack = 1'b0; memAddr = '0; dataBusIn = '0;
    expRead("ack_vs_wr_gie", A_CTRL, 32'h0);
    expRead("ack_vs_wr_icause", A_CAUSE, 32'h8000_0001);

    // Reset while in SERVICE
    reset = 1'b0;
    tick();
    reset = 1'b1;
    expReq(1'b0, 4'd0); cmpReq("rst_svc");
    expRead("rst_svc_icause", A_CAUSE, 32'h0);
    expRead("rst_svc_imask", A_MASK, 32'h0);
    expRead("rst_svc_ictrl", A_CTRL, 32'h0);
    expReq(1'b0, 4'd0); tick(); cmpReq("rst_svc_idle");

    // Simultaneous we/re is a write and reads zero
    memAddr = A_MASK; dataBusIn = 32'h5; we = 1'b1; re = 1'b1;
    #1;
    expectVal(32'h0); checkVal("we_re_bus", dataBusOut);
    tick();
    we = 1'b0; re = 1'b0; memAddr = '0; dataBusIn = '0;
    expRead("we_re_imask", A_MASK, 32'h5);

    // IPEND mirrors irq_in one edge later; unmapped reads are zero
    irq_in = 4'b0110;
    tick();
    expRead("ipend_0110", A_PEND, 32'h6);
    expRead("unmapped", A_CAUSE + 32'd4, 32'h0);

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expected values left over", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Memory-mapped interrupt controller directly downstream of the I/O devices: consumes their level-sensitive interrupt-ready outputs (key, switch, timer) and presents one prioritised request plus an id to the processor pipeline.
- Holds the global enable, per-line mask, live pending view and in-service cause.
- Sequences a request/acknowledge/return handshake with the CPU.
- Supports one interrupt in service at a time; nesting is not supported.

Parameters:
- BITS, 32, data/address bus width
- NUM_IRQ, 4, number of interrupt lines; range 1..16
- BASE, 32'hF0000100, address of ICTRL; IMASK = BASE+4, IPEND = BASE+8, ICAUSE = BASE+12

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- we  input  1  CPU store strobe
- re  input  1  CPU load strobe
- memAddr  input  BITS  bus address
- dataBusIn  input  BITS  store data
- irq_in  input  NUM_IRQ  level interrupt lines; bit i = device i
- intr_ack  input  1  CPU has vectored to the handler
- intr_ret  input  1  CPU executed return-from-interrupt
- dataBusOut  output  BITS  load data; all zeros when not selected
- intr_req  output  1  interrupt request to CPU
- intr_id  output  4  id of requested / in-service line

Behaviour:
- Reset (reset==0 at an edge): ICTRL=0, IMASK=0, IPEND=0, cause=0, state IDLE. Outputs are then intr_req=0, intr_id=0, dataBusOut=0.
- Registers:
  - ICTRL: bit0 GIE, read/write; other bits read 0.
  - IMASK: bits[NUM_IRQ-1:0] read/write; 1 = enabled.
  - IPEND: read-only registered copy of irq_in, updated every cycle.
  - ICAUSE: read-only; bits[3:0] in-service id, bit31 valid (set only in SERVICE).
- Bus write: we==1 and address match -> register loads dataBusIn at the edge. Writes to IPEND/ICAUSE are ignored.
- Bus read: re==1, we==0 and address match -> dataBusOut combinationally drives the register value. Otherwise dataBusOut is 0, so the bus can be OR-combined.
- Eligible vector: elig = IPEND & IMASK & {NUM_IRQ{GIE}}. The winner is the lowest-index set bit (index 0 has highest priority).
- FSM, states IDLE, REQUEST, SERVICE:
  - IDLE: if elig != 0 -> REQUEST and latch winner into intr_id.
  - REQUEST: intr_req=1.
    - If intr_ack -> SERVICE. Cause id = intr_id, ICAUSE valid=1, GIE forced to 0.
    - Else if elig bit intr_id drops (device cleared it, or masked) -> IDLE, intr_req=0.
    - The id stays fixed during REQUEST; a higher-priority arrival does not pre-empt before ack.
  - SERVICE: intr_req=0, intr_id holds cause.
    - intr_ret -> IDLE, ICAUSE valid=0, GIE restored to 1.
    - The handler's writes to ICTRL in SERVICE take effect, but intr_ret still forces GIE=1.
- Latency:
  - irq_in rising at edge N -> IPEND set at N -> REQUEST entered at edge N+1 -> intr_req high during cycle N+1 (two edges from sampling).
  - intr_req drops in the cycle after ack is sampled.
- Boundary conditions:
  - intr_ack outside REQUEST, and intr_ret outside SERVICE, are ignored.
  - intr_ack and irq drop in the same cycle: ack wins and SERVICE is entered.
  - Bus write to IMASK in the same cycle as the IDLE->REQUEST transition: the transition uses the old mask. The new mask is evaluated in REQUEST next cycle and can withdraw the request.
  - Bus write to ICTRL.GIE coinciding with ack: the ack-forced 0 wins.
  - Reset in any state returns to IDLE within the same edge; an in-flight request is dropped without ack.
  - irq_in bits above NUM_IRQ do not exist; intr_id upper bits are 0.

Decomposition:
- Shared package:
  - register offsets (ICTRL 0, IMASK 4, IPEND 8, ICAUSE 12)
  - FSM state encoding (2-bit: IDLE=0, REQUEST=1, SERVICE=2)
  - ICAUSE valid bit position 31
  - GIE bit position 0
- Sub-module priority_encoder (parameter NUM_IRQ): input vector -> 4-bit lowest-set index plus any-valid flag.
- State and registers use the existing Register block.

Test Plan:
- Reset, then read all four addresses -> all return 0. Set GIE=1 and IMASK=4'b0001, then pulse irq_in[0] high -> intr_req=1, intr_id=0 two edges after irq_in rises.
- GIE=1, IMASK=4'b1111, irq_in=4'b1010 -> intr_id=1. Ack -> intr_req=0, ICAUSE=32'h8000_0001, ICTRL reads 0. intr_ret -> ICAUSE=0, ICTRL=1; with irq_in still 4'b1010, a new request with id 1 follows.
- In REQUEST with id 2, drop irq_in[2] before ack -> intr_req returns to 0 next cycle and the state is IDLE. Repeat with IMASK bit 2 written to 0 -> same outcome.
- During SERVICE for id 3, raise irq_in[0] -> no intr_req until intr_ret; then intr_req=1, intr_id=0.
- Assert intr_ack in IDLE and intr_ret in REQUEST -> no state change. Assert reset (0) while in SERVICE -> the next cycle shows intr_req=0, ICAUSE=0, IMASK=0, GIE=0.
- Read IMASK with we=1 and re=1 simultaneously -> treated as a write, dataBusOut=0. Read IPEND with irq_in=4'b0110 -> 32'h6 one cycle later.
